// File: rtl/fft_pass_sequencer_pkg.sv
// Shared constants for the mixed-radix DFT pass sequencer: FSM state codes,
// radix codes, default sizes and the radix-order helper.
package fft_seq_pkg;

  localparam int DEF_AW     = 11;
  localparam int DEF_S2_MAX = 11;
  localparam int DEF_S3_MAX = 6;
  localparam int DEF_S5_MAX = 3;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_FACT5 = 4'd1;
  localparam logic [3:0] ST_FACT3 = 4'd2;
  localparam logic [3:0] ST_FACT2 = 4'd3;
  localparam logic [3:0] ST_CHECK = 4'd4;
  localparam logic [3:0] ST_ISSUE = 4'd5;
  localparam logic [3:0] ST_WAIT  = 4'd6;
  localparam logic [3:0] ST_DONE  = 4'd7;
  localparam logic [3:0] ST_ERR   = 4'd8;

  localparam logic [1:0] RAD_NONE = 2'b00;
  localparam logic [1:0] RAD_R5   = 2'b01;
  localparam logic [1:0] RAD_R3   = 2'b10;
  localparam logic [1:0] RAD_R2   = 2'b11;

  // First radix after 'cur' (in R5, R3, R2 order) that still has stages.
  function automatic logic [1:0] next_radix(input logic [1:0] cur, input logic nz5,
                                            input logic nz3, input logic nz2);
    logic [1:0] r;
    r = RAD_NONE;
    case (cur)
      RAD_NONE: r = nz5 ? RAD_R5 : (nz3 ? RAD_R3 : (nz2 ? RAD_R2 : RAD_NONE));
      RAD_R5:   r = nz3 ? RAD_R3 : (nz2 ? RAD_R2 : RAD_NONE);
      RAD_R3:   r = nz2 ? RAD_R2 : RAD_NONE;
      default:  r = RAD_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fft_pass_sequencer_if.sv
// Job request / pass control bundle between the sequencer (master) and the
// surrounding datapath that requests jobs and runs the engines (slave).
interface fft_pass_sequencer_if #(parameter int AW = 11);
  logic          start;
  logic [AW-1:0] last_address;
  logic          pass_done;
  logic [3:0]    stages2;
  logic [2:0]    stages3;
  logic [1:0]    stages5;
  logic [AW-1:0] points;
  logic          cfg_valid;
  logic          pass_start;
  logic [1:0]    pass_radix;
  logic [3:0]    pass_index;
  logic          busy;
  logic          finish;
  logic          err;

  modport master (
    input  start, last_address, pass_done,
    output stages2, stages3, stages5, points, cfg_valid, pass_start,
           pass_radix, pass_index, busy, finish, err
  );

  modport slave (
    output start, last_address, pass_done,
    input  stages2, stages3, stages5, points, cfg_valid, pass_start,
           pass_radix, pass_index, busy, finish, err
  );
endinterface

// File: rtl/fft_factorizer.sv
// Holds the residual size n and the per-radix stage counters; one division
// per step strobe, plus the end-of-factorization legality check.
module fft_factorizer
  import fft_seq_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int S2_MAX = DEF_S2_MAX,
  parameter int S3_MAX = DEF_S3_MAX,
  parameter int S5_MAX = DEF_S5_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] last_address,
  input  logic          step5,
  input  logic          step3,
  input  logic          step2,
  output logic          div5,
  output logic          div3,
  output logic          div2,
  output logic [3:0]    stages2,
  output logic [2:0]    stages3,
  output logic [1:0]    stages5,
  output logic          cfg_err
);

  localparam logic [AW:0] K1 = (AW+1)'(1);
  localparam logic [AW:0] K2 = (AW+1)'(2);
  localparam logic [AW:0] K3 = (AW+1)'(3);
  localparam logic [AW:0] K5 = (AW+1)'(5);

  logic [AW:0] n_q, n_d;
  logic [3:0]  s2_q, s2_d;
  logic [2:0]  s3_q, s3_d;
  logic [1:0]  s5_q, s5_d;
  logic [2:0]  ovf_q, ovf_d;  // {r2, r3, r5}: increment attempted at field maximum

  assign div5 = (n_q % K5) == '0;
  assign div3 = (n_q % K3) == '0;
  assign div2 = (n_q % K2) == '0;

  always_comb begin
    n_d   = n_q;
    s2_d  = s2_q;
    s3_d  = s3_q;
    s5_d  = s5_q;
    ovf_d = ovf_q;
    if (load) begin
      n_d   = {1'b0, last_address} + K1;
      s2_d  = '0;
      s3_d  = '0;
      s5_d  = '0;
      ovf_d = '0;
    end else if (step5) begin
      n_d = n_q / K5;
      if (&s5_q) ovf_d[0] = 1'b1;
      else       s5_d = s5_q + 2'd1;
    end else if (step3) begin
      n_d = n_q / K3;
      if (&s3_q) ovf_d[1] = 1'b1;
      else       s3_d = s3_q + 3'd1;
    end else if (step2) begin
      n_d = n_q / K2;
      if (&s2_q) ovf_d[2] = 1'b1;
      else       s2_d = s2_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q   <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      s5_q  <= '0;
      ovf_q <= '0;
    end else begin
      n_q   <= n_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      s5_q  <= s5_d;
      ovf_q <= ovf_d;
    end
  end

  // A residue of 1 with no stages at all means N was 1.
  always_comb begin
    cfg_err = (n_q != K1)
           || ((s2_q == '0) && (s3_q == '0) && (s5_q == '0))
           || (|ovf_q)
           || (int'(s2_q) > S2_MAX)
           || (int'(s3_q) > S3_MAX)
           || (int'(s5_q) > S5_MAX);
  end

  assign stages2 = s2_q;
  assign stages3 = s3_q;
  assign stages5 = s5_q;

endmodule

// File: rtl/fft_pass_sequencer.sv
// Factorizes a DFT job size and issues one pass per radix stage to the shared
// FFT5/FFT3/FFT2 engines, radix-5 first, waiting for each pass to complete.
module fft_pass_sequencer
  import fft_seq_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int S2_MAX = DEF_S2_MAX,
  parameter int S3_MAX = DEF_S3_MAX,
  parameter int S5_MAX = DEF_S5_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_pass_sequencer_if.master bus
);

  logic [3:0]    state_q, state_d;
  logic          start_prev_q, start_prev_d;
  logic [1:0]    radix_q, radix_d;
  logic [3:0]    index_q, index_d;
  logic          cfg_valid_q, cfg_valid_d;
  logic [AW-1:0] points_q, points_d;

  logic       start_rise, load, step5, step3, step2;
  logic       div5, div3, div2, cfg_err;
  logic [3:0] s2, cur_cnt;
  logic [2:0] s3;
  logic [1:0] s5, nxt_radix;

  fft_factorizer #(
    .AW(AW), .S2_MAX(S2_MAX), .S3_MAX(S3_MAX), .S5_MAX(S5_MAX)
  ) u_fact (
    .clk(clk), .rst(rst), .load(load), .last_address(bus.last_address),
    .step5(step5), .step3(step3), .step2(step2),
    .div5(div5), .div3(div3), .div2(div2),
    .stages2(s2), .stages3(s3), .stages5(s5), .cfg_err(cfg_err)
  );

  assign start_prev_d = bus.start;
  assign start_rise   = bus.start & ~start_prev_q;
  assign nxt_radix    = next_radix(radix_q, |s5, |s3, |s2);

  always_comb begin
    case (radix_q)
      RAD_R5:  cur_cnt = {2'b00, s5};
      RAD_R3:  cur_cnt = {1'b0, s3};
      RAD_R2:  cur_cnt = s2;
      default: cur_cnt = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    radix_d     = radix_q;
    index_d     = index_q;
    cfg_valid_d = cfg_valid_q;
    points_d    = points_q;
    load        = 1'b0;
    step5       = 1'b0;
    step3       = 1'b0;
    step2       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          load        = 1'b1;
          cfg_valid_d = 1'b0;
          points_d    = bus.last_address;
          state_d     = ST_FACT5;
        end
      end
      ST_FACT5: begin
        if (div5) step5 = 1'b1;
        else      state_d = ST_FACT3;
      end
      ST_FACT3: begin
        if (div3) step3 = 1'b1;
        else      state_d = ST_FACT2;
      end
      ST_FACT2: begin
        if (div2) step2 = 1'b1;
        else      state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (cfg_err) begin
          state_d = ST_ERR;
        end else begin
          cfg_valid_d = 1'b1;
          radix_d     = nxt_radix;
          index_d     = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.pass_done) begin
          if (4'(index_q + 4'd1) < cur_cnt) begin
            index_d = index_q + 4'd1;
            state_d = ST_ISSUE;
          end else if (nxt_radix != RAD_NONE) begin
            radix_d = nxt_radix;
            index_d = '0;
            state_d = ST_ISSUE;
          end else begin
            radix_d = RAD_NONE;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR: begin
        cfg_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      radix_q      <= RAD_NONE;
      index_q      <= '0;
      cfg_valid_q  <= 1'b0;
      points_q     <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      radix_q      <= radix_d;
      index_q      <= index_d;
      cfg_valid_q  <= cfg_valid_d;
      points_q     <= points_d;
    end
  end

  // Pulses are plain state decodes, so each lasts exactly one cycle.
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.pass_start = (state_q == ST_ISSUE);
  assign bus.finish     = (state_q == ST_DONE);
  assign bus.err        = (state_q == ST_ERR);
  assign bus.pass_radix = radix_q;
  assign bus.pass_index = index_q;
  assign bus.cfg_valid  = cfg_valid_q;
  assign bus.points     = points_q;
  assign bus.stages2    = s2;
  assign bus.stages3    = s3;
  assign bus.stages5    = s5;

endmodule

// File: tb/tb_fft_pass_sequencer.sv
// Directed bench for fft_pass_sequencer: stands in for the FFT engines,
// answering each pass_start and checking pass order, timing and error paths.
module tb_fft_pass_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fft_pass_sequencer_if #(.AW(11)) bus_if ();

  fft_pass_sequencer #(.AW(11)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},   bus_if.busy, 0);
    check_eq({tag, "_ps"},     bus_if.pass_start, 0);
    check_eq({tag, "_radix"},  bus_if.pass_radix, 0);
    check_eq({tag, "_index"},  bus_if.pass_index, 0);
    check_eq({tag, "_cfg"},    bus_if.cfg_valid, 0);
    check_eq({tag, "_s2"},     bus_if.stages2, 0);
    check_eq({tag, "_s3"},     bus_if.stages3, 0);
    check_eq({tag, "_s5"},     bus_if.stages5, 0);
    check_eq({tag, "_points"}, bus_if.points, 0);
    check_eq({tag, "_finish"}, bus_if.finish, 0);
    check_eq({tag, "_err"},    bus_if.err, 0);
  endtask

  // Full job: e2/e3/e5 are the hand-factorized stage counts of la+1.
  task automatic run_job(input logic [10:0] la, input int e2, input int e3,
                         input int e5, input bit noisy);
    int cyc;
    int npass;
    int exp_r[$];
    int exp_i[$];
    bit got;
    npass = e2 + e3 + e5;
    for (int i = 0; i < e5; i++) begin exp_r.push_back(1); exp_i.push_back(i); end
    for (int i = 0; i < e3; i++) begin exp_r.push_back(2); exp_i.push_back(i); end
    for (int i = 0; i < e2; i++) begin exp_r.push_back(3); exp_i.push_back(i); end

    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.last_address = la;
    @(negedge clk);
    cyc = 1;
    bus_if.start = 1'b0;
    check_eq("job_busy_rise", bus_if.busy, 1);
    check_eq("job_cfg_clear", bus_if.cfg_valid, 0);
    check_eq("job_s2_clear", bus_if.stages2, 0);

    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus_if.pass_start) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check_eq("first_ps_seen", got, 1);
    if (!got) return;
    check_eq("first_ps_latency", cyc, npass + 5);
    check_eq("stages2", bus_if.stages2, e2);
    check_eq("stages3", bus_if.stages3, e3);
    check_eq("stages5", bus_if.stages5, e5);
    check_eq("cfg_valid", bus_if.cfg_valid, 1);
    check_eq("points", bus_if.points, int'(la));

    for (int p = 0; p < npass; p++) begin
      check_eq("pass_radix", bus_if.pass_radix, exp_r[p]);
      check_eq("pass_index", bus_if.pass_index, exp_i[p]);
      if (noisy) begin
        bus_if.pass_done = 1'b1;  // lands in ISSUE: must be ignored
        if (p == 0) bus_if.start = 1'b1;
      end
      @(negedge clk);
      bus_if.pass_done = 1'b0;
      bus_if.start = 1'b0;
      check_eq("ps_one_cycle", bus_if.pass_start, 0);
      @(negedge clk);
      bus_if.pass_done = 1'b1;
      if (noisy && p == npass - 1) bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.pass_done = 1'b0;
      if (p < npass - 1) check_eq("ps_after_done", bus_if.pass_start, 1);
    end

    check_eq("finish_pulse", bus_if.finish, 1);
    check_eq("busy_in_done", bus_if.busy, 1);
    check_eq("radix_none_done", bus_if.pass_radix, 0);
    @(negedge clk);
    bus_if.start = 1'b0;
    check_eq("finish_one_cycle", bus_if.finish, 0);
    check_eq("busy_fall", bus_if.busy, 0);
    check_eq("cfg_hold", bus_if.cfg_valid, 1);
    check_eq("s2_hold", bus_if.stages2, e2);
    repeat (3) @(negedge clk);
    check_eq("idle_stays", bus_if.busy, 0);
  endtask

  // Unsupported size: err pulse in cycle e_cyc after the start edge.
  task automatic err_job(input logic [10:0] la, input int e_cyc, input int e5);
    int cyc;
    int err_at;
    int nerr;
    int nps;
    err_at = -1;
    nerr = 0;
    nps = 0;
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.last_address = la;
    @(negedge clk);
    bus_if.start = 1'b0;
    cyc = 1;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.err) begin
        nerr++;
        if (err_at < 0) err_at = cyc;
      end
      if (bus_if.pass_start) nps++;
      if (err_at >= 0 && cyc == err_at + 1) begin
        check_eq("err_then_idle", bus_if.busy, 0);
        check_eq("err_cfg_clear", bus_if.cfg_valid, 0);
      end
      @(negedge clk);
      cyc++;
    end
    check_eq("err_cycle", err_at, e_cyc);
    check_eq("err_count", nerr, 1);
    check_eq("err_no_pass", nps, 0);
    check_eq("err_stages5", bus_if.stages5, e5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    rst = 1'b0;
    bus_if.start = 1'b0;
    bus_if.last_address = '0;
    bus_if.pass_done = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_job(11'd11, 2, 1, 0, 1'b0);     // N=12
    run_job(11'd1199, 4, 1, 2, 1'b0);   // N=1200
    err_job(11'd6, 5, 0);               // N=7
    err_job(11'd624, 9, 3);             // N=625, radix-5 overflow
    err_job(11'd0, 5, 0);               // N=1

    // Reset in the WAIT of pass R5#1 of N=1200
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.last_address = 11'd1199;
    @(negedge clk);
    bus_if.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus_if.pass_start) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("rst_first_ps", got, 1);
    @(negedge clk);
    bus_if.pass_done = 1'b1;
    @(negedge clk);
    bus_if.pass_done = 1'b0;
    check_eq("rst_ps_r5_1", bus_if.pass_start, 1);
    check_eq("rst_index_1", bus_if.pass_index, 1);
    check_eq("rst_radix_r5", bus_if.pass_radix, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("midwait_reset");
    @(negedge clk);
    bus_if.pass_done = 1'b1;
    @(negedge clk);
    bus_if.pass_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    bus_if.pass_done = 1'b1;
    @(negedge clk);
    bus_if.pass_done = 1'b0;
    check_eq("late_done_no_ps", bus_if.pass_start, 0);
    check_eq("late_done_idle", bus_if.busy, 0);
    repeat (2) @(negedge clk);
    check_eq("late_done_still_idle", bus_if.busy, 0);

    run_job(11'd11, 2, 1, 0, 1'b0);     // clean run after reset
    run_job(11'd1199, 4, 1, 2, 1'b1);   // spurious start / pass_done
    run_job(11'd2047, 11, 0, 0, 1'b0);  // N=2048

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
